// File: rtl/multicycle_cpu_pkg.sv
// Shared ISA encodings, FSM states and ALU operations for the multi-cycle core.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  typedef enum logic [2:0] {ADD, SUB, AND, OR, SLT} alu_op_t;

  // True for every opcode/funct pair the core implements.
  function automatic logic is_legal(input logic [5:0] op, input logic [5:0] funct);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_RTYPE: ok = (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
                     (funct == FN_OR)  || (funct == FN_SLT);
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Maps an R-type funct field onto the ALU operation.
  function automatic alu_op_t funct_to_alu(input logic [5:0] funct);
    alu_op_t res;
    case (funct)
      FN_SUB:  res = SUB;
      FN_AND:  res = AND;
      FN_OR:   res = OR;
      FN_SLT:  res = SLT;
      default: res = ADD;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/multicycle_cpu_if.sv
// Shared instruction/data memory port with a req/ack handshake.
interface multicycle_cpu_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_ack;

  modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                  input  mem_rdata, mem_ack);

  modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                  output mem_rdata, mem_ack);
endinterface

// File: rtl/multicycle_cpu_alu.sv
// Combinational integer ALU with zero flag, shared with the pipelined core.
module alu_n
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  alu_op_t               op,
  output logic [DATA_WIDTH-1:0] y,
  output logic                  zero
);

  // Result select; arithmetic wraps, slt compares as signed.
  always_comb begin
    y = '0;
    case (op)
      ADD:     y = a + b;
      SUB:     y = a - b;
      AND:     y = a & b;
      OR:      y = a | b;
      SLT:     y = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle MIPS-I subset core: one shared memory port, FETCH..WB state machine.
module multicycle_cpu
  import cpu_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    REG_COUNT  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  multicycle_cpu_if.master      mem,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic                  wb_en,
  output logic [DATA_WIDTH-1:0] wb_data,
  output logic                  halted
);

  localparam int RIDX = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  state_t                state, state_d;
  logic [31:0]           ir;
  logic [DATA_WIDTH-1:0] a, b, mdr, alu_out;
  logic [DATA_WIDTH-1:0] regs [REG_COUNT];

  logic [5:0]            op, funct;
  logic [15:0]           imm;
  logic [25:0]           target;
  logic [RIDX-1:0]       rs_idx, rt_idx, rd_idx, wb_idx;
  logic [DATA_WIDTH-1:0] rd_a, rd_b, imm_ext, alu_b, alu_y;
  logic [ADDR_WIDTH-1:0] branch_off, jump_pc;
  logic                  alu_zero;
  alu_op_t               alu_op;

  assign op       = ir[31:26];
  assign funct    = ir[5:0];
  assign imm      = ir[15:0];
  assign target   = ir[25:0];
  assign rs_idx   = ir[21 +: RIDX];
  assign rt_idx   = ir[16 +: RIDX];
  assign rd_idx   = ir[11 +: RIDX];
  assign wb_idx   = (op == OP_RTYPE) ? rd_idx : rt_idx;
  assign imm_ext  = {{(DATA_WIDTH-16){imm[15]}}, imm};
  assign rd_a     = (rs_idx == '0) ? '0 : regs[rs_idx];
  assign rd_b     = (rt_idx == '0) ? '0 : regs[rt_idx];
  assign wb_data  = (op == OP_LW) ? mdr : alu_out;
  assign halted   = (state == HALT);

  // Operand, ALU-op and branch/jump target selection from the latched instruction.
  always_comb begin
    alu_op = ADD;
    if (op == OP_RTYPE) alu_op = funct_to_alu(funct);
    else if (op == OP_BEQ) alu_op = SUB;
    alu_b      = ((op == OP_RTYPE) || (op == OP_BEQ)) ? b : imm_ext;
    branch_off = {{(ADDR_WIDTH-18){imm[15]}}, imm, 2'b00};
    jump_pc        = pc;
    jump_pc[27:0]  = {target, 2'b00};
  end

  alu_n #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .a    (a),
    .b    (alu_b),
    .op   (alu_op),
    .y    (alu_y),
    .zero (alu_zero)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state <= FETCH;
    else      state <= state_d;
  end

  // Next-state logic and Moore memory-port outputs, gated off while in reset.
  always_comb begin
    state_d       = state;
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = pc;
    mem.mem_wdata = b;
    wb_en         = 1'b0;
    case (state)
      FETCH: begin
        mem.mem_req = rst;
        if (mem.mem_ack) state_d = DECODE;
      end
      DECODE: state_d = is_legal(op, funct) ? EXEC : HALT;
      EXEC: begin
        if ((op == OP_RTYPE) || (op == OP_ADDI))  state_d = WB;
        else if ((op == OP_LW) || (op == OP_SW))  state_d = MEM;
        else                                      state_d = FETCH;
      end
      MEM: begin
        mem.mem_req  = rst;
        mem.mem_we   = (op == OP_SW);
        mem.mem_addr = ADDR_WIDTH'(alu_out);
        if (mem.mem_ack) state_d = (op == OP_LW) ? WB : FETCH;
      end
      WB: begin
        wb_en   = rst;
        state_d = FETCH;
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // Datapath registers: PC, IR, operand latches, ALU result and MDR.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc      <= RESET_PC;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      mdr     <= '0;
      alu_out <= '0;
    end else begin
      case (state)
        FETCH: if (mem.mem_ack) begin
          ir <= mem.mem_rdata[31:0];
          pc <= pc + PC_STEP;
        end
        DECODE: begin
          a <= rd_a;
          b <= rd_b;
        end
        EXEC: begin
          alu_out <= alu_y;
          if ((op == OP_BEQ) && alu_zero) pc <= pc + branch_off;
          if (op == OP_J)                 pc <= jump_pc;
        end
        MEM: if (mem.mem_ack && (op == OP_LW)) mdr <= mem.mem_rdata;
        default: ;
      endcase
    end
  end

  // Register file write port; register 0 is never written.
  always_ff @(posedge clk) begin
    if (wb_en && (wb_idx != '0)) regs[wb_idx] <= wb_data;
  end

endmodule

// File: tb/tb_multicycle_cpu.sv
// Scoreboard bench for multicycle_cpu: wait-state memory model, write-back/store/fetch queues.
module tb_multicycle_cpu;
  import cpu_pkg::*;

  logic        clk, rst;
  logic [31:0] pc;
  logic        wb_en;
  logic [31:0] wb_data;
  logic        halted;

  multicycle_cpu_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) ifc ();

  multicycle_cpu #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .REG_COUNT  (32),
    .RESET_PC   (32'h0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .mem     (ifc),
    .pc      (pc),
    .wb_en   (wb_en),
    .wb_data (wb_data),
    .halted  (halted)
  );

  typedef struct packed { logic [31:0] data; int cyc; } wb_exp_t;
  typedef struct packed { logic [31:0] addr; logic [31:0] data; } st_exp_t;
  typedef struct packed { logic [31:0] addr; int cyc; } fetch_exp_t;

  wb_exp_t    wb_q[$];
  st_exp_t    st_q[$];
  fetch_exp_t f_q[$];

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  bit          force_ack = 1'b1;
  bit          fetch_check = 1'b0;
  logic [31:0] mem [128];

  bit          in_txn = 1'b0;
  logic [31:0] t_addr, t_wdata;
  logic        t_we;
  int          t_len = 0;
  bit          t_stable = 1'b1;
  int          last_rd_cyc = 0;
  logic [31:0] last_rd_addr = '0;
  int          wb_seen = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: sim time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input logic [5:0] fn);
    logic [4:0] s, t, d;
    s = rs[4:0]; t = rt[4:0]; d = rd[4:0];
    return {OP_RTYPE, s, t, d, 5'd0, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] opc, input int rs, input int rt, input logic [15:0] im);
    logic [4:0] s, t;
    s = rs[4:0]; t = rt[4:0];
    return {opc, s, t, im};
  endfunction

  function automatic logic [31:0] enc_j(input logic [25:0] tgt);
    return {OP_J, tgt};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic failNow(input string name, input logic [63:0] actual);
    total++;
    bad++;
    $display("[TB] FAIL %s: got %0h with nothing expected (t=%0t)", name, actual, $time);
  endtask

  // Cycle number since reset release; cycle 1 is the first cycle with rst high.
  always @(posedge clk) begin
    if (!rst) cyc = 1;
    else      cyc = cyc + 1;
  end

  // Memory model: acks after ack_delay wait cycles, writes commit with the ack.
  always @(negedge clk) begin
    if (force_ack) begin
      ifc.mem_ack   = 1'b1;
      ifc.mem_rdata = '0;
      wait_cnt      = 0;
    end else if (ifc.mem_req) begin
      if (wait_cnt >= ack_delay) begin
        ifc.mem_ack   = 1'b1;
        ifc.mem_rdata = mem[ifc.mem_addr[8:2]];
        if (ifc.mem_we) mem[ifc.mem_addr[8:2]] = ifc.mem_wdata;
        wait_cnt = 0;
      end else begin
        ifc.mem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      ifc.mem_ack = 1'b0;
      wait_cnt    = 0;
    end
  end

  // Monitor: transaction stability/length, store and fetch scoreboards, write-back scoreboard.
  always @(negedge clk) begin
    #1;
    if (rst !== 1'b1) begin
      in_txn = 1'b0;
    end else begin
      if (ifc.mem_req) begin
        if (!in_txn) begin
          in_txn   = 1'b1;
          t_addr   = ifc.mem_addr;
          t_we     = ifc.mem_we;
          t_wdata  = ifc.mem_wdata;
          t_len    = 0;
          t_stable = 1'b1;
        end else if ((t_addr !== ifc.mem_addr) || (t_we !== ifc.mem_we) ||
                     (t_we && (t_wdata !== ifc.mem_wdata))) begin
          t_stable = 1'b0;
        end
        t_len++;
        if (ifc.mem_ack) begin
          in_txn = 1'b0;
          checkOutput("txn_stable", t_stable, 1);
          checkOutput("txn_len", t_len, ack_delay + 1);
          if (t_we) begin
            if (st_q.size() == 0) failNow("store_unexpected", t_addr);
            else begin
              st_exp_t s;
              s = st_q.pop_front();
              checkOutput("store_addr", t_addr, s.addr);
              checkOutput("store_data", t_wdata, s.data);
            end
          end else begin
            last_rd_cyc  = cyc;
            last_rd_addr = t_addr;
            if (fetch_check && (f_q.size() > 0)) begin
              fetch_exp_t f;
              f = f_q.pop_front();
              checkOutput("fetch_addr", t_addr, f.addr);
              checkOutput("fetch_cycle", cyc, f.cyc);
            end
          end
        end
      end else begin
        in_txn = 1'b0;
      end
      if (wb_en) begin
        wb_seen++;
        if (wb_q.size() == 0) failNow("wb_unexpected", wb_data);
        else begin
          wb_exp_t w;
          w = wb_q.pop_front();
          checkOutput("wb_data", wb_data, w.data);
          if (w.cyc >= 0) checkOutput("wb_cycle", cyc, w.cyc);
        end
      end
    end
  end

  task automatic pushWb(input logic [31:0] d, input int c);
    wb_q.push_back('{data: d, cyc: c});
  endtask

  task automatic holdReset();
    @(posedge clk); #2 rst = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic clearMem();
    for (int i = 0; i < 128; i++) mem[i] = 32'h0;
  endtask

  // Releases reset with the given wait-state count; cycle 1 follows.
  task automatic applyStimulus(input int delay);
    ack_delay = delay;
    force_ack = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
  endtask

  task automatic waitCycle(input int target);
    int n;
    n = 0;
    while ((cyc != target) && (n < 500)) begin
      @(negedge clk); #2;
      n++;
    end
    if (cyc != target) failNow("cycle_timeout", cyc);
  endtask

  task automatic waitHalt(input logic [31:0] illegal_addr);
    int n;
    n = 0;
    while (!halted && (n < 400)) begin
      @(negedge clk); #2;
      n++;
    end
    if (!halted) failNow("halt_timeout", pc);
    else begin
      checkOutput("halt_latency", cyc - last_rd_cyc, 2);
      checkOutput("halt_fetch_addr", last_rd_addr, illegal_addr);
      checkOutput("halt_pc", pc, illegal_addr + 4);
    end
  endtask

  task automatic checkDrained(input string tag);
    checkOutput({tag, "_wb_left"}, wb_q.size(), 0);
    checkOutput({tag, "_st_left"}, st_q.size(), 0);
  endtask

  initial begin
    int req_seen;
    int wb_base;
    rst = 1'b0;

    // Reset with a stuck-high ack: no request, PC at reset value.
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    checkOutput("rst_mem_req", ifc.mem_req, 0);
    checkOutput("rst_pc", pc, 0);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_wb_en", wb_en, 0);

    // ALU program at zero wait states, ending on an illegal opcode.
    clearMem();
    mem[0]  = enc_i(OP_ADDI, 0, 1, 16'd5);
    mem[1]  = enc_i(OP_ADDI, 0, 2, 16'd7);
    mem[2]  = enc_r(1, 2, 3, FN_ADD);
    mem[3]  = enc_i(OP_SW, 0, 3, 16'd128);
    mem[4]  = enc_r(1, 2, 5, FN_SUB);
    mem[5]  = enc_r(5, 1, 6, FN_SLT);
    mem[6]  = enc_r(3, 2, 7, FN_AND);
    mem[7]  = enc_r(3, 2, 8, FN_OR);
    mem[8]  = enc_i(OP_ADDI, 0, 0, 16'd9);
    mem[9]  = enc_r(0, 1, 9, FN_ADD);
    mem[10] = 32'hFC00_0000;
    pushWb(32'd5, -1);
    pushWb(32'd7, -1);
    pushWb(32'd12, 12);
    st_q.push_back('{addr: 32'd128, data: 32'd12});
    pushWb(32'hFFFF_FFFE, -1);
    pushWb(32'd1, -1);
    pushWb(32'd4, -1);
    pushWb(32'd15, -1);
    pushWb(32'd9, -1);
    pushWb(32'd5, -1);
    applyStimulus(0);
    @(negedge clk); #2;
    checkOutput("first_req", ifc.mem_req, 1);
    checkOutput("first_addr", ifc.mem_addr, 0);
    checkOutput("first_we", ifc.mem_we, 0);
    waitHalt(32'd40);
    req_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #2;
      if (ifc.mem_req) req_seen++;
    end
    checkOutput("halt_no_req", req_seen, 0);
    checkOutput("halt_stays", halted, 1);
    checkDrained("alu");

    // Store then load through 3 wait states.
    holdReset();
    clearMem();
    mem[0]  = enc_i(OP_ADDI, 0, 1, 16'd5);
    mem[1]  = enc_i(OP_ADDI, 0, 2, 16'd7);
    mem[2]  = enc_j(26'd8);
    mem[8]  = enc_i(OP_SW, 1, 2, 16'd8);
    mem[9]  = enc_i(OP_LW, 1, 4, 16'd8);
    mem[10] = 32'hFC00_0000;
    pushWb(32'd5, -1);
    pushWb(32'd7, -1);
    st_q.push_back('{addr: 32'd13, data: 32'd7});
    pushWb(32'd7, -1);
    applyStimulus(3);
    waitHalt(32'd40);
    checkDrained("ldst");

    // Branches and jump: fetch addresses and cycles at zero wait.
    holdReset();
    clearMem();
    mem[0] = enc_i(OP_ADDI, 0, 1, 16'd5);
    mem[1] = enc_i(OP_ADDI, 0, 2, 16'd7);
    mem[2] = enc_i(OP_BEQ, 1, 2, 16'd4);
    mem[3] = enc_j(26'd8);
    mem[4] = 32'hFC00_0000;
    mem[8] = enc_i(OP_BEQ, 1, 1, 16'hFFFF);
    pushWb(32'd5, -1);
    pushWb(32'd7, -1);
    f_q.push_back('{addr: 32'd0,  cyc: 1});
    f_q.push_back('{addr: 32'd4,  cyc: 5});
    f_q.push_back('{addr: 32'd8,  cyc: 9});
    f_q.push_back('{addr: 32'd12, cyc: 12});
    f_q.push_back('{addr: 32'd32, cyc: 15});
    f_q.push_back('{addr: 32'd32, cyc: 18});
    f_q.push_back('{addr: 32'd32, cyc: 21});
    fetch_check = 1'b1;
    applyStimulus(0);
    waitCycle(23);
    checkOutput("branch_fetch_left", f_q.size(), 0);
    checkOutput("branch_not_halted", halted, 0);
    checkDrained("branch");
    fetch_check = 1'b0;

    // Reset during a load's memory wait abandons it cleanly.
    holdReset();
    clearMem();
    mem[0] = enc_i(OP_LW, 0, 4, 16'd8);
    mem[2] = 32'h0000_1234;
    applyStimulus(3);
    waitCycle(7);
    checkOutput("lw_mem_req", ifc.mem_req, 1);
    checkOutput("lw_mem_addr", ifc.mem_addr, 8);
    checkOutput("lw_mem_we", ifc.mem_we, 0);
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk); #2;
    checkOutput("abort_mem_req", ifc.mem_req, 0);
    checkOutput("abort_wb_en", wb_en, 0);
    wb_base = wb_seen;
    f_q.push_back('{addr: 32'd0, cyc: 4});
    fetch_check = 1'b1;
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk); #2;
    checkOutput("abort_pc", pc, 0);
    waitCycle(9);
    checkOutput("abort_refetch_left", f_q.size(), 0);
    checkOutput("abort_no_wb", wb_seen - wb_base, 0);
    fetch_check = 1'b0;
    holdReset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
